ec_serial_acc: RTL
==================

// Module: ec_serial_acc
// PURPOSE
//  Bit-serial error-compensation accumulator, one stage downstream of the per-column
//  3:2 compensation cell. Accepts one column of 3 error bits per beat, LSB column
//  first, over COLS beats.
//  Each beat it applies the same 3:2 compress plus {cout,sout} add, with the two
//  column carries held in registers. It emits a packed compensation word equal to
//  sum(popcount(err_in[k]) * 2^k), which the product adder consumes.
// PARAMETERS
//  COLS   8        number of columns per frame (>=2)
//  OUT_W  COLS+2   compensation word width (derived; do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      err_in carries a valid column
//  in_ready   out  1      accumulator can accept a column
//  err_in     in   3      error bits of current column (weight 2^col each)
//  out_valid  out  1      comp_out holds a finished frame result
//  out_ready  in   1      consumer accepts comp_out
//  comp_out   out  OUT_W  compensation word
//  sat_out    out  1      result was clamped (0 when EC_SAT_EN undefined)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=ACC, col=0, cin_q=0, carry_q=0, word=0,
//    in_ready=1, out_valid=0, comp_out=0, sat_out=0. Applies immediately; a partial
//    frame is discarded.
//  - State ACC:
//    - in_ready=1, out_valid=0.
//    - A beat is in_valid&in_ready; no-valid cycles hold all state.
//  - Per beat:
//    - {c,s} = 3:2(err_in); c = maj(err_in), s = xor(err_in).
//    - {co,so} = s + cin_q + carry_q (2 bits).
//    - word[col] <= so; cin_q <= co; carry_q <= c; col <= col+1.
//  - Last beat (col==COLS-1):
//    - word[COLS+1:COLS] <= co + c (0..2).
//    - col <= 0; cin_q, carry_q <= 0.
//    - state <= DONE.
//  - State DONE:
//    - in_ready=0, out_valid=1.
//    - comp_out and sat_out are registered and held stable until out_ready.
//    - in_valid is ignored.
//  - DONE & out_ready: state <= ACC and word <= 0 at next edge. in_ready rises that
//    edge; no bubble beyond 1 cycle.
//  - Latency: comp_out valid the cycle after the last accepted beat; min frame
//    period is COLS+1 cycles.
//  - Width: max result 3*(2^COLS-1) < 2^OUT_W, so there is no overflow. All adds are
//    unsigned.
//  - col counter is ceil(log2(COLS)) bits and wraps only via the last-beat reset.
// CONFIGURATION
//  - EC_SAT_EN defined:
//    - On the last beat, if the full result > 2^COLS-1, comp_out = 2^COLS-1 (upper
//      2 bits 0) and sat_out=1; else sat_out=0.
//    - Costs one comparator and does not change latency.
//  - EC_SAT_EN undefined:
//    - comp_out is the exact OUT_W-bit sum.
//    - sat_out is tied 0.
// TESTING (COLS=8)
//  1. 8 beats err_in=3'b000 -> out_valid after beat 8, comp_out=0, sat_out=0.
//  2. 8 beats err_in=3'b111 -> comp_out=765 (0x2FD) without EC_SAT_EN;
//     255, sat_out=1 with it.
//  3. col0=3'b011, col1=3'b101, col7=3'b001, rest 0 -> comp_out=2+4+128=134.
//  4. in_valid gaps (random idle cycles between beats) -> same result as gap-free
//     frame, 134.
//  5. Hold out_ready=0 5 cycles in DONE while in_valid=1 -> comp_out stable,
//     in_ready=0, no beats consumed.
//  6. rst_n low after 4 beats, then full frame of 3'b111 -> comp_out=765, no
//     residue from aborted frame.

Source files
------------

// File: rtl/ec_serial_acc_if.sv
// rtl/ec_serial_acc_if.sv - column-in / result-out handshake bundle for ec_serial_acc
interface ec_serial_acc_if #(
    parameter int COLS = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       err_in;
    logic             out_valid;
    logic             out_ready;
    logic [COLS+1:0]  comp_out;
    logic             sat_out;

    modport master (
        output in_valid, err_in, out_ready,
        input  in_ready, out_valid, comp_out, sat_out
    );

    modport slave (
        input  in_valid, err_in, out_ready,
        output in_ready, out_valid, comp_out, sat_out
    );
endinterface

// File: rtl/ec_serial_acc.sv
// rtl/ec_serial_acc.sv - bit-serial error-compensation accumulator (optional clamp: EC_SAT_EN)
module ec_serial_acc #(
    parameter int COLS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ec_serial_acc_if.slave bus
);
    localparam int OUT_W = COLS + 2;
    localparam int COL_W = $clog2(COLS);
    localparam logic [OUT_W-1:0] SAT_MAX = {2'b00, {COLS{1'b1}}};

    typedef enum logic {ACC, DONE} state_t;

    state_t             state_q;
    logic [COL_W-1:0]   col_q;
    logic               cin_q;
    logic               carry_q;
    logic [OUT_W-1:0]   word_q;
    logic               sat_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               c, s, co, so, last;
    logic [1:0]         add_sum;
    logic [1:0]         top;
    logic [OUT_W-1:0]   word_d;
    logic [OUT_W-1:0]   full_d;
    logic [OUT_W-1:0]   result_d;
    logic               sat_d;

    // 3:2 compress of the column, then fold in the two carries arriving from below
    always_comb begin
        c       = (bus.err_in[0] & bus.err_in[1]) | (bus.err_in[0] & bus.err_in[2]) |
                  (bus.err_in[1] & bus.err_in[2]);
        s       = ^bus.err_in;
        add_sum = {1'b0, s} + {1'b0, cin_q} + {1'b0, carry_q};
        co      = add_sum[1];
        so      = add_sum[0];
        top     = {1'b0, co} + {1'b0, c};
        last    = (col_q == COL_W'(COLS - 1));
        word_d  = word_q;
        word_d[col_q] = so;
        full_d  = {top, so, word_q[COLS-2:0]};
`ifdef EC_SAT_EN
        sat_d    = (full_d > SAT_MAX);
        result_d = sat_d ? SAT_MAX : full_d;
`else
        sat_d    = 1'b0;
        result_d = full_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            col_q       <= '0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            word_q      <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        if (last) begin
                            word_q      <= result_d;
                            sat_q       <= sat_d;
                            col_q       <= '0;
                            cin_q       <= 1'b0;
                            carry_q     <= 1'b0;
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            word_q  <= word_d;
                            cin_q   <= co;
                            carry_q <= c;
                            col_q   <= col_q + COL_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; new columns wait.
                    if (bus.out_ready) begin
                        state_q     <= ACC;
                        word_q      <= '0;
                        sat_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.comp_out  = word_q;
    assign bus.sat_out   = sat_q;
endmodule
